// File: rtl/comfort_ramp_ctrl_if.sv
// rtl/comfort_ramp_ctrl_if.sv - access/setpoint bundle between the sequencer and its neighbours
interface comfort_ramp_ctrl_if #(
  parameter int W = 8
);
  logic         pass_check;
  logic         start;
  logic [W-1:0] T_ideal;
  logic [W-1:0] L_ideal;
  logic [W-1:0] T_sens;
  logic [W-1:0] L_sens;
  logic [W-1:0] T_set;
  logic [W-1:0] L_set;
  logic         busy;
  logic         act_stb;
  logic         act_sel;
  logic         done;
  logic         aborted;

  modport master (
    output pass_check, start, T_ideal, L_ideal, T_sens, L_sens,
    input  T_set, L_set, busy, act_stb, act_sel, done, aborted
  );

  modport slave (
    input  pass_check, start, T_ideal, L_ideal, T_sens, L_sens,
    output T_set, L_set, busy, act_stb, act_sel, done, aborted
  );
endinterface

// File: rtl/comfort_ramp_ctrl.sv
// rtl/comfort_ramp_ctrl.sv - clocked round-robin ramp of temperature/light setpoints
module comfort_ramp_ctrl #(
  parameter int STEP_DIV = 10,
  parameter int W        = 8
) (
  input logic               clk,
  input logic               rst,
  comfort_ramp_ctrl_if.slave bus
);
  localparam int            CW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rr;
  logic [W-1:0]  t_tgt, l_tgt;
  logic [W-1:0]  t_set, l_set;
  logic          busy, act_stb, act_sel, done, aborted;

  logic t_pend, l_pend, sel;

  assign t_pend = (t_set != t_tgt);
  assign l_pend = (l_set != l_tgt);
  // Round-robin only arbitrates when both channels still need steps.
  assign sel    = (t_pend && l_pend) ? rr : l_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rr      <= 1'b0;
      t_tgt   <= '0;
      l_tgt   <= '0;
      t_set   <= '0;
      l_set   <= '0;
      busy    <= 1'b0;
      act_stb <= 1'b0;
      act_sel <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      act_stb <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.pass_check) begin
            t_set <= bus.T_sens;
            l_set <= bus.L_sens;
            t_tgt <= bus.T_ideal;
            l_tgt <= bus.L_ideal;
            busy  <= 1'b1;
            rr    <= 1'b0;
            cnt   <= RELOAD;
            state <= RAMP;
          end
        end
        RAMP: begin
          if (!bus.pass_check) begin
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt <= RELOAD;
            if (!t_pend && !l_pend) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              act_stb <= 1'b1;
              act_sel <= sel;
              rr      <= ~sel;
              // Steps only move toward the latched target, so no wrap is possible.
              if (!sel) t_set <= (t_set < t_tgt) ? t_set + W'(1) : t_set - W'(1);
              else      l_set <= (l_set < l_tgt) ? l_set + W'(1) : l_set - W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.T_set   = t_set;
  assign bus.L_set   = l_set;
  assign bus.busy    = busy;
  assign bus.act_stb = act_stb;
  assign bus.act_sel = act_sel;
  assign bus.done    = done;
  assign bus.aborted = aborted;
endmodule

// File: doc/comfort_ramp_ctrl.md
# comfort_ramp_ctrl

Sequencing controller for the home-automation comfort system: once access is granted (`pass_check`), it ramps the temperature and lighting setpoints from the sensed values toward the ideal values one LSB per step, on a programmable step interval. The two channels share one actuator update slot and are served round-robin. It replaces delay-based ramping with a synthesizable, clocked state machine and sits between the password checker and the HVAC/lighting actuator drivers.

## Interface
- `STEP_DIV`, 10, clock cycles between successive step slots (≥1)
- `W`, 8, width of all temperature/light values
- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  reset, asynchronous, active-high
- `pass_check`  in  1  access granted; must stay high for the whole ramp
- `start`  in  1  request a ramp (sampled in IDLE only)
- `T_ideal`, `L_ideal`  in  W  target setpoints (latched at start)
- `T_sens`, `L_sens`  in  W  sensed values (loaded as ramp origin at start)
- `T_set`, `L_set`  out  W  current setpoints to actuators
- `busy`  out  1  ramp in progress
- `act_stb`  out  1  one-cycle pulse: a setpoint changed this cycle
- `act_sel`  out  1  channel updated by the last step (0 = T, 1 = L)
- `done`  out  1  one-cycle pulse: both setpoints reached target
- `aborted`  out  1  one-cycle pulse: ramp cancelled by loss of `pass_check`

## Operation
- States: IDLE, RAMP.
- IDLE: on an edge with `start`=1 and `pass_check`=1, do all of the following and go to RAMP:
  - set `T_set`<=`T_sens` and `L_set`<=`L_sens`
  - latch `T_ideal`/`L_ideal` into internal targets
  - set `busy`<=1, round-robin pointer `rr`<=0 (T first), interval counter <=`STEP_DIV`-1
- `start` with `pass_check`=0 is ignored.
- RAMP, each cycle, in priority order:
  1. `pass_check`=0: next edge -> IDLE, `busy`=0, `aborted`=1 for one cycle; setpoints hold their current values.
  2. Counter ≠ 0: decrement.
  3. Counter = 0 (step slot): reload `STEP_DIV`-1, then:
     - Both channels equal to target: `done`=1 for one cycle, `busy`=0, -> IDLE; no `act_stb`.
     - Both pending: step the channel selected by `rr`, then set `rr` to the other channel.
     - One pending: step that channel, then set `rr` to the other channel.
     - A step moves the setpoint ±1 toward its target (increment if below, decrement if above). In the step cycle `act_stb`=1 and `act_sel`=channel.
- Setpoints only move toward a latched target, so no overflow or wrap-around occurs at 0 or 2^W-1.
- `start`, `T_ideal`, `L_ideal`, `T_sens` and `L_sens` are ignored while in RAMP.
- `T_set`/`L_set` hold their values in IDLE indefinitely.

## Timing
- Reset (asynchronous, immediate): state IDLE; `T_set`=0, `L_set`=0, `busy`=0, `act_stb`=0, `act_sel`=0, `done`=0, `aborted`=0, `rr`=0.
- Reset mid-ramp aborts without an `aborted` pulse.
- Let edge k accept `start`. Then:
  - k: `busy` and the loaded setpoints are visible after edge k.
  - k + n·`STEP_DIV`: step n takes effect (n = 1..N), where N = |ΔT|+|ΔL|.
  - k + (N+1)·`STEP_DIV`: `done` asserts.
- `done`, `aborted` and `act_stb` are registered, one-cycle pulses and are mutually exclusive.
- Abort latency: one edge after `pass_check` is sampled low.
- A new `start` is accepted no earlier than the edge after `done` or `aborted`, i.e. once back in IDLE.
- Counter width is ceil(log2(`STEP_DIV`)), minimum 1. With `STEP_DIV`=1 a step slot occurs every cycle.

## Test plan
All scenarios use `STEP_DIV`=4.
- Mixed up-ramp: `T_sens`=20, `T_ideal`=23, `L_sens`=50, `L_ideal`=51, start at k -> T=21 @k+4 (`act_sel`=0), L=51 @k+8 (`act_sel`=1), T=22 @k+12, T=23 @k+16, `done` @k+20, `busy` low after.
- Down-ramp: `T_sens`=30, `T_ideal`=28, `L_sens`=`L_ideal`=10 -> T=29 @k+4, T=28 @k+8, `done` @k+12; `L_set` stays 10.
- Already at target: `T_sens`=`T_ideal`=25, `L_sens`=`L_ideal`=40 -> no `act_stb`, `done` @k+4.
- Abort: the up-ramp case with `pass_check` dropped during cycle k+6 -> `aborted` pulse on the next edge, `busy`=0, T=21 and L=50 held, no `done`.
- Ignored inputs:
  - `start` with `pass_check`=0 -> no response.
  - `start` pulse and `T_ideal`=99 applied at k+5 of a ramp -> trajectory unchanged.
- Asynchronous reset asserted at k+9 between clock edges -> all outputs 0 immediately. A new `start` after release ramps correctly from the new sensed values.
